// File: rtl/invaders_pkg.sv
// Shared state encoding and default geometry for the invaders game-logic blocks.
// Constants only: no logic, no latency, no flow control.
package invaders_pkg;

   localparam int COORD_W_DEF    = 10;
   localparam int SCREEN_W_DEF   = 640;
   localparam int N_ENEMY_DEF    = 8;
   localparam int ENEMY_SIZE_DEF = 25;
   localparam int ENEMY_GAP_DEF  = 10;
   localparam int STEP_DOWN_DEF  = 10;
   localparam int SHIP_W_DEF     = 25;
   localparam int SHIP_Y_DEF     = 450;
   localparam int SHIP_H_DEF     = 10;
   localparam int BULLET_LEN_DEF = 25;
   localparam int BULLET_W_DEF   = 3;
   localparam int SCORE_W_DEF    = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_WIN  = 2'd2,
      ST_LOSE = 2'd3
   } game_state_e;

endpackage

// File: rtl/rect_hit.sv
// Point-in-half-open-rectangle test; purely combinational, zero latency, no flow control.
// Sums are widened so rectangle ends past the coordinate range never wrap.
module rect_hit #(
   parameter int COORD_W = 10
) (
   input  logic [COORD_W-1:0] px_i,
   input  logic [COORD_W-1:0] py_i,
   input  logic [COORD_W:0]   rx_i,
   input  logic [COORD_W:0]   ry_i,
   input  logic [COORD_W:0]   rw_i,
   input  logic [COORD_W:0]   rh_i,
   output logic               hit_o
);

   logic [COORD_W+1:0] px_w, py_w, x_lo, y_lo, x_hi, y_hi;

   assign px_w = {2'b00, px_i};
   assign py_w = {2'b00, py_i};
   assign x_lo = {1'b0, rx_i};
   assign y_lo = {1'b0, ry_i};
   assign x_hi = {1'b0, rx_i} + {1'b0, rw_i};
   assign y_hi = {1'b0, ry_i} + {1'b0, rh_i};

   assign hit_o = (px_w >= x_lo) && (px_w < x_hi) && (py_w >= y_lo) && (py_w < y_hi);

endmodule

// File: rtl/invader_wave_core.sv
// Invaders game logic: formation of N_ENEMY enemies, ship, bullet, score and game FSM.
// State advances on iTick only; pixel flags are combinational (zero latency); no backpressure.
module invader_wave_core
   import invaders_pkg::*;
#(
   parameter int COORD_W    = COORD_W_DEF,
   parameter int SCREEN_W   = SCREEN_W_DEF,
   parameter int N_ENEMY    = N_ENEMY_DEF,
   parameter int ENEMY_SIZE = ENEMY_SIZE_DEF,
   parameter int ENEMY_GAP  = ENEMY_GAP_DEF,
   parameter int STEP_DOWN  = STEP_DOWN_DEF,
   parameter int SHIP_W     = SHIP_W_DEF,
   parameter int SHIP_Y     = SHIP_Y_DEF,
   parameter int SHIP_H     = SHIP_H_DEF,
   parameter int BULLET_LEN = BULLET_LEN_DEF,
   parameter int BULLET_W   = BULLET_W_DEF,
   parameter int SCORE_W    = SCORE_W_DEF
) (
   input  logic               iClock,
   input  logic               iReset,
   input  logic               iTick,
   input  logic               iLeft,
   input  logic               iRight,
   input  logic               iFire,
   input  logic               iStart,
   input  logic [COORD_W-1:0] iX,
   input  logic [COORD_W-1:0] iY,
   output logic [1:0]         oState,
   output logic [SCORE_W-1:0] oScore,
   output logic [N_ENEMY-1:0] oAlive,
   output logic               oShip,
   output logic               oBullet,
   output logic               oEnemy,
   output logic               oHitPulse
);

   localparam logic [COORD_W:0]   FW_W       = (COORD_W+1)'(N_ENEMY*ENEMY_SIZE + (N_ENEMY-1)*ENEMY_GAP);
   localparam logic [COORD_W:0]   SCREEN_W_W = (COORD_W+1)'(SCREEN_W);
   localparam logic [COORD_W:0]   ESIZE_W    = (COORD_W+1)'(ENEMY_SIZE);
   localparam logic [COORD_W:0]   SHIP_Y_W   = (COORD_W+1)'(SHIP_Y);
   localparam logic [COORD_W:0]   SHIP_W_W   = (COORD_W+1)'(SHIP_W);
   localparam logic [COORD_W:0]   SHIP_H_W   = (COORD_W+1)'(SHIP_H);
   localparam logic [COORD_W:0]   BUL_W_W    = (COORD_W+1)'(BULLET_W);
   localparam logic [COORD_W:0]   BUL_LEN_W  = (COORD_W+1)'(BULLET_LEN);
   localparam logic [COORD_W-1:0] SHIP_X0    = COORD_W'((SCREEN_W-SHIP_W)/2);
   localparam logic [COORD_W-1:0] SHIP_X_MAX = COORD_W'(SCREEN_W-SHIP_W);
   localparam logic [COORD_W-1:0] BUL_X_OFS  = COORD_W'(SHIP_W/2);
   localparam logic [COORD_W-1:0] BUL_Y0     = COORD_W'(SHIP_Y-BULLET_LEN);
   localparam logic [COORD_W-1:0] STEP_W     = COORD_W'(STEP_DOWN);

   game_state_e        state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [N_ENEMY-1:0] alive_q, alive_d;
   logic [COORD_W-1:0] form_x_q, form_x_d, form_y_q, form_y_d;
   logic [COORD_W-1:0] ship_x_q, ship_x_d;
   logic [COORD_W-1:0] bul_x_q, bul_x_d, bul_y_q, bul_y_d;
   logic               dir_left_q, dir_left_d;
   logic               bul_act_q, bul_act_d;
   logic               hit_q, hit_d;

   logic [N_ENEMY-1:0] pix_hit, tip_hit, kill_mask;
   logic [COORD_W:0]   form_x_end;
   logic               ship_pix, bul_pix;

   // Each enemy gets two comparators: one against the raster pixel, one against the bullet tip.
   for (genvar gi = 0; gi < N_ENEMY; gi++) begin : g_enemy
      logic [COORD_W:0] ex;
      assign ex = {1'b0, form_x_q} + (COORD_W+1)'(gi*(ENEMY_SIZE+ENEMY_GAP));

      rect_hit #(.COORD_W(COORD_W)) u_pix (
         .px_i(iX), .py_i(iY), .rx_i(ex), .ry_i({1'b0, form_y_q}),
         .rw_i(ESIZE_W), .rh_i(ESIZE_W), .hit_o(pix_hit[gi])
      );
      rect_hit #(.COORD_W(COORD_W)) u_tip (
         .px_i(bul_x_q), .py_i(bul_y_q), .rx_i(ex), .ry_i({1'b0, form_y_q}),
         .rw_i(ESIZE_W), .rh_i(ESIZE_W), .hit_o(tip_hit[gi])
      );
   end

   rect_hit #(.COORD_W(COORD_W)) u_ship (
      .px_i(iX), .py_i(iY), .rx_i({1'b0, ship_x_q}), .ry_i(SHIP_Y_W),
      .rw_i(SHIP_W_W), .rh_i(SHIP_H_W), .hit_o(ship_pix)
   );
   rect_hit #(.COORD_W(COORD_W)) u_bullet (
      .px_i(iX), .py_i(iY), .rx_i({1'b0, bul_x_q}), .ry_i({1'b0, bul_y_q}),
      .rw_i(BUL_W_W), .rh_i(BUL_LEN_W), .hit_o(bul_pix)
   );

   // Only the lowest-index alive enemy under the tip is destroyed.
   always_comb begin
      kill_mask = '0;
      for (int i = 0; i < N_ENEMY; i++) begin
         if (tip_hit[i] && alive_q[i] && (kill_mask == '0)) kill_mask[i] = 1'b1;
      end
   end

   assign form_x_end = {1'b0, form_x_q} + FW_W;

   always_comb begin
      state_d    = state_q;
      score_d    = score_q;
      alive_d    = alive_q;
      form_x_d   = form_x_q;
      form_y_d   = form_y_q;
      dir_left_d = dir_left_q;
      ship_x_d   = ship_x_q;
      bul_act_d  = bul_act_q;
      bul_x_d    = bul_x_q;
      bul_y_d    = bul_y_q;
      hit_d      = 1'b0;
      if (iTick) begin
         case (state_q)
            ST_PLAY: begin
               if (iLeft && !iRight && (ship_x_q != '0)) ship_x_d = ship_x_q - 1'b1;
               else if (iRight && !iLeft && (ship_x_q < SHIP_X_MAX)) ship_x_d = ship_x_q + 1'b1;

               if (!bul_act_q) begin
                  if (iFire) begin
                     bul_act_d = 1'b1;
                     bul_x_d   = ship_x_q + BUL_X_OFS;
                     bul_y_d   = BUL_Y0;
                  end
               end else if (kill_mask != '0) begin
                  alive_d   = alive_q & ~kill_mask;
                  bul_act_d = 1'b0;
                  hit_d     = 1'b1;
                  if (score_q != '1) score_d = score_q + 1'b1;
               end else if (bul_y_q == '0) begin
                  bul_act_d = 1'b0;
               end else begin
                  bul_y_d = bul_y_q - 1'b1;
               end

               if (!dir_left_q && (form_x_end == SCREEN_W_W)) begin
                  dir_left_d = 1'b1;
                  form_y_d   = form_y_q + STEP_W;
               end else if (dir_left_q && (form_x_q == '0)) begin
                  dir_left_d = 1'b0;
                  form_y_d   = form_y_q + STEP_W;
               end else if (dir_left_q) begin
                  form_x_d = form_x_q - 1'b1;
               end else begin
                  form_x_d = form_x_q + 1'b1;
               end

               if (alive_d == '0) state_d = ST_WIN;
               else if (({1'b0, form_y_q} + ESIZE_W) >= SHIP_Y_W) state_d = ST_LOSE;
            end
            default: begin
               if (iStart) begin
                  state_d    = ST_PLAY;
                  score_d    = '0;
                  alive_d    = '1;
                  form_x_d   = '0;
                  form_y_d   = '0;
                  dir_left_d = 1'b0;
                  ship_x_d   = SHIP_X0;
                  bul_act_d  = 1'b0;
                  bul_x_d    = '0;
                  bul_y_d    = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q    <= ST_IDLE;
         score_q    <= '0;
         alive_q    <= '1;
         form_x_q   <= '0;
         form_y_q   <= '0;
         dir_left_q <= 1'b0;
         ship_x_q   <= SHIP_X0;
         bul_act_q  <= 1'b0;
         bul_x_q    <= '0;
         bul_y_q    <= '0;
         hit_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         score_q    <= score_d;
         alive_q    <= alive_d;
         form_x_q   <= form_x_d;
         form_y_q   <= form_y_d;
         dir_left_q <= dir_left_d;
         ship_x_q   <= ship_x_d;
         bul_act_q  <= bul_act_d;
         bul_x_q    <= bul_x_d;
         bul_y_q    <= bul_y_d;
         hit_q      <= hit_d;
      end
   end

   assign oState    = state_q;
   assign oScore    = score_q;
   assign oAlive    = alive_q;
   assign oHitPulse = hit_q;
   assign oShip     = ship_pix;
   assign oBullet   = bul_act_q && bul_pix;
   assign oEnemy    = |(pix_hit & alive_q);

endmodule

// File: doc/invader_wave_core.md
Name: invader_wave_core

Overview:
Parametrised game-logic core for the invaders display. It generalises the single-enemy design to a row of N_ENEMY enemies that move as one formation, each with its own alive bit. It adds a game state machine, a score counter and a game-step enable in place of a divided clock. It sits between the debounced KEY/SW inputs and the VGA colour mux, and produces per-pixel ship/bullet/enemy flags from the vga_sync x,y coordinates.

Parameters:
COORD_W, 10, width of every x/y coordinate
SCREEN_W, 640, visible width in pixels
N_ENEMY, 8, enemies in the formation (1..16)
ENEMY_SIZE, 25, enemy square side in pixels
ENEMY_GAP, 10, horizontal gap between adjacent enemies
STEP_DOWN, 10, formation drop per edge bounce
SHIP_W, 25, ship width
SHIP_Y, 450, ship top row
SHIP_H, 10, ship height
BULLET_LEN, 25, bullet height
BULLET_W, 3, bullet width
SCORE_W, 8, score counter width

Ports:
iClock  in  1  system clock
iReset  in  1  synchronous reset, active-high
iTick  in  1  one-cycle game-step enable
iLeft  in  1  move ship left, active-high, already debounced
iRight  in  1  move ship right, active-high
iFire  in  1  fire request, active-high
iStart  in  1  start/restart request, level, sampled on tick
iX  in  COORD_W  current pixel x from vga_sync
iY  in  COORD_W  current pixel y from vga_sync
oState  out  2  0 IDLE, 1 PLAY, 2 WIN, 3 LOSE
oScore  out  SCORE_W  enemies destroyed, saturating
oAlive  out  N_ENEMY  per-enemy alive mask
oShip  out  1  pixel (iX,iY) is inside the ship
oBullet  out  1  pixel is inside the active bullet
oEnemy  out  1  pixel is inside any alive enemy
oHitPulse  out  1  one-cycle pulse on each kill

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. All registers update only when iTick=1, except on reset.
- Reset values: state=IDLE, score=0, alive=all ones, formX=0, formY=0, dir=right, shipX=(SCREEN_W-SHIP_W)/2, bullet inactive, bulletX=0, bulletY=0, oHitPulse=0.
- Reset asserted mid-PLAY returns all registers to the reset values on the next clock edge.
- Geometry: every range is half-open. Enemy i occupies x in [formX+i*(ENEMY_SIZE+ENEMY_GAP), +ENEMY_SIZE) and y in [formY, formY+ENEMY_SIZE). Formation width FW = N_ENEMY*ENEMY_SIZE + (N_ENEMY-1)*ENEMY_GAP.
- FSM in IDLE: a tick with iStart=1 loads the reset values except state, which becomes PLAY. Score is cleared.
- FSM in WIN or LOSE: all objects are frozen. A tick with iStart=1 loads the reset values with state=PLAY.
- In PLAY, each tick evaluates from the registered values in this order, with all results committed together:
  1. Ship: iLeft&~iRight with shipX>0 gives shipX-1. iRight&~iLeft with shipX<SCREEN_W-SHIP_W gives shipX+1. Both pressed or neither gives no move.
  2. Bullet, when inactive: iFire loads bulletX=shipX+SHIP_W/2 and bulletY=SHIP_Y-BULLET_LEN, and sets active.
  3. Bullet, when active: the tip is the point (bulletX, bulletY).
     - Tip inside an alive enemy: clear the lowest such index in alive, deactivate the bullet, score+1 (saturates at all ones), oHitPulse=1 for this cycle only.
     - Otherwise, bulletY==0: deactivate.
     - Otherwise: bulletY-1.
  4. Formation:
     - dir=right and formX+FW==SCREEN_W: dir becomes left, formY+=STEP_DOWN, no x move this tick.
     - dir=left and formX==0: dir becomes right, formY+=STEP_DOWN, no x move this tick.
     - Otherwise formX±1.
     - Formation motion is independent of a hit on the same tick.
  5. End conditions: the next alive value is 0 gives WIN. Else formY+ENEMY_SIZE>=SHIP_Y (from the registered formY) gives LOSE. WIN has priority over LOSE on the same tick.
- oHitPulse is 0 on every cycle that is not a kill tick.
- Pixel outputs are combinational from iX,iY and the registers, with zero latency.
  - oShip: x in [shipX, shipX+SHIP_W) and y in [SHIP_Y, SHIP_Y+SHIP_H).
  - oBullet: active, x in [bulletX, bulletX+BULLET_W) and y in [bulletY, bulletY+BULLET_LEN).
  - oEnemy: OR over alive enemies.
  - Drawn in all states.
- Width rules: all coordinate sums are computed at COORD_W+1 bits to avoid wrap. Parameters guarantee FW<=SCREEN_W.

Decomposition:
- Shared package invaders_pkg: state encoding (IDLE/PLAY/WIN/LOSE), COORD_W, screen constants.
- One natural sub-module: rect_hit (point-in-half-open-rectangle compare, parametrised by COORD_W). It is instantiated for the ship, the bullet, each enemy's pixel test and each enemy's bullet-tip test.

Test Plan:
1. Defaults; reset, then 3 ticks with iStart=0 -> state IDLE, score 0, oAlive 0xFF, shipX 307, oShip=1 at (307,450), 0 at (332,450).
2. Start, then 370 ticks -> formX 370, formY 0. Next tick -> formX 370, formY 10, dir left. Following tick -> formX 369.
3. Start; hold iLeft 307 ticks -> shipX 0. 310 further iLeft ticks -> shipX stays 0. iLeft+iRight together -> no move.
4. N_ENEMY=1, start, shipX 307, fire at the tick where the bullet tip meets the enemy box -> oHitPulse high exactly one cycle, oAlive 0, score 1, state WIN on that tick, further ticks frozen.
5. Start, never fire -> formY steps 10 per bounce. On the tick evaluated with formY=430 -> state LOSE. formX/formY frozen afterwards. iStart tick -> PLAY with reset positions, score 0.
6. Mid-PLAY with the bullet active and score 3, assert iReset one cycle -> next edge state IDLE, score 0, bullet inactive, oAlive all ones.
